// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer driving one external 1-bit
// full-adder cell. Operands are captured on an accepted start. They are then
// presented to the cell LSB first, one bit per clock. The carry is fed back
// through a register and the sum bits are assembled in a shift register.
// The WIDTH-bit result and the final carry are returned with a one-cycle done pulse.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c_in,
  input  logic             fa_sum,
  input  logic             fa_c_out
);

  // The counter only needs to reach WIDTH-1; the extra headroom keeps WIDTH=1 legal.
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_sh_q;
  logic [WIDTH-1:0] sum_sh_d;
  logic [WIDTH-1:0] sum_q;
  logic             cy_q;
  logic             c_out_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;

  // Next sum shift-register value: this cycle's cell sum bit enters at the MSB.
  always_comb begin
    sum_sh_d = WIDTH'({fa_sum, sum_sh_q} >> 1);
  end

  // Cell inputs come straight from the operand/carry registers, gated off outside RUN.
  assign fa_a    = (state_q == RUN) & a_sh_q[0];
  assign fa_b    = (state_q == RUN) & b_sh_q[0];
  assign fa_c_in = (state_q == RUN) & cy_q;

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = c_out_q;

  // Sequencer: capture on start, shift one bit per RUN cycle, publish the result on the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      cy_q     <= 1'b0;
      c_out_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            cy_q    <= c_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          // start is deliberately ignored here; the captured operands stay untouched.
          sum_sh_q <= sum_sh_d;
          cy_q     <= fa_c_out;
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          if (cnt_q == LAST) begin
            // Hold cnt at LAST so it never wraps.
            sum_q   <= sum_sh_d;
            c_out_q <= fa_c_out;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl. It contains a WIDTH=8 instance and a WIDTH=1
// instance, and each instance is wired to its own behavioural full-adder cell.
// The expected results come from plain integer addition of the operands.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst;

  // WIDTH=8 instance signals
  logic       start;
  logic [7:0] a, b;
  logic       c_in;
  logic       busy, done, c_out;
  logic [7:0] sum;
  logic       fa_a, fa_b, fa_c_in, fa_sum, fa_c_out;

  // WIDTH=1 instance signals
  logic       start1;
  logic [0:0] a1, b1, sum1;
  logic       c_in1;
  logic       busy1, done1, c_out1;
  logic       fa1_a, fa1_b, fa1_c_in, fa1_sum, fa1_c_out;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
    .busy(busy), .done(done), .sum(sum), .c_out(c_out),
    .fa_a(fa_a), .fa_b(fa_b), .fa_c_in(fa_c_in),
    .fa_sum(fa_sum), .fa_c_out(fa_c_out)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c_in(c_in1),
    .busy(busy1), .done(done1), .sum(sum1), .c_out(c_out1),
    .fa_a(fa1_a), .fa_b(fa1_b), .fa_c_in(fa1_c_in),
    .fa_sum(fa1_sum), .fa_c_out(fa1_c_out)
  );

  // Full-adder cells
  assign {fa_c_out, fa_sum}   = 2'(fa_a) + 2'(fa_b) + 2'(fa_c_in);
  assign {fa1_c_out, fa1_sum} = 2'(fa1_a) + 2'(fa1_b) + 2'(fa1_c_in);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One add on the WIDTH=8 instance. The run checks latency, busy length, result and final carry.
  // If mid is set, start is pulsed with other operands partway through RUN.
  task automatic run_add(input logic [7:0] av, input logic [7:0] bv, input logic cv, input bit mid);
    logic [8:0] exp;
    int n, busyc;
    bit seen;
    exp = 9'(av) + 9'(bv) + 9'(cv);
    @(negedge clk);
    start = 1'b1; a = av; b = bv; c_in = cv;
    @(posedge clk); #1;
    busyc = 0;
    if (busy) busyc++;
    chk("accept_no_done", 32'(done), 32'(0));
    n = 0;
    seen = 1'b0;
    while (!seen && n < 30) begin
      @(negedge clk);
      start = mid && (n == 3);
      a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
      @(posedge clk); #1;
      n++;
      if (busy) busyc++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    chk("done_seen", 32'(seen), 32'(1));
    chk("latency", 32'(n), 32'(8));
    chk("busy_cycles", 32'(busyc), 32'(8));
    chk("sum", 32'(sum), 32'(exp[7:0]));
    chk("c_out", 32'(c_out), 32'(exp[8]));
  endtask

  // Quiet cycles after a result: check that done is a single pulse, the result holds and the cell inputs are zero.
  task automatic idle_check(input logic [7:0] es, input logic ec);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("idle_done", 32'(done), 32'(0));
      chk("idle_busy", 32'(busy), 32'(0));
      chk("hold_sum", 32'(sum), 32'(es));
      chk("hold_c_out", 32'(c_out), 32'(ec));
      chk("idle_fa", 32'({fa_a, fa_b, fa_c_in}), 32'(0));
    end
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] rexp;
    int         nd;
    rst = 1'b1;
    start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; c_in1 = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_sum", 32'(sum), 32'(0));
    chk("rst_c_out", 32'(c_out), 32'(0));
    chk("rst_fa", 32'({fa_a, fa_b, fa_c_in}), 32'(0));
    chk("rst_w1", 32'({busy1, done1, sum1, c_out1}), 32'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Directed cases
    run_add(8'h3C, 8'h0F, 1'b0, 1'b0);
    idle_check(8'h4B, 1'b0);
    run_add(8'hFF, 8'h01, 1'b0, 1'b0);
    idle_check(8'h00, 1'b1);
    run_add(8'hA5, 8'h5A, 1'b1, 1'b0);
    run_add(8'h01, 8'h01, 1'b0, 1'b0);   // start issued in the DONE cycle
    idle_check(8'h02, 1'b0);
    run_add(8'h55, 8'h33, 1'b0, 1'b1);   // start pulsed during RUN must be ignored
    idle_check(8'h88, 1'b0);

    // Reset in the middle of an add
    @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'hFF; c_in = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_done", 32'(done), 32'(0));
    chk("midrst_sum", 32'(sum), 32'(0));
    chk("midrst_c_out", 32'(c_out), 32'(0));
    chk("midrst_fa", 32'({fa_a, fa_b, fa_c_in}), 32'(0));
    @(negedge clk) rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) nd++;
    end
    chk("no_done_after_rst", 32'(nd), 32'(0));
    chk("sum_after_rst", 32'({c_out, sum}), 32'(0));
    run_add(8'h10, 8'h20, 1'b0, 1'b0);
    idle_check(8'h30, 1'b0);

    // Randomized adds against the integer reference
    for (int i = 0; i < 25; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      rexp = 9'(ra) + 9'(rb) + 9'(rc);
      run_add(ra, rb, rc, 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle_check(rexp[7:0], rexp[8]);
    end

    // WIDTH=1: full-adder truth table, one RUN cycle per add
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic [1:0] e;
      v = 3'(i);
      e = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      @(negedge clk);
      start1 = 1'b1; a1 = v[2]; b1 = v[1]; c_in1 = v[0];
      @(posedge clk); #1;
      chk("w1_busy", 32'(busy1), 32'(1));
      @(negedge clk);
      start1 = 1'b0; a1 = '0; b1 = '0; c_in1 = 1'b0;
      @(posedge clk); #1;
      chk("w1_done", 32'(done1), 32'(1));
      chk("w1_result", 32'({c_out1, sum1}), 32'(e));
      @(posedge clk); #1;
      chk("w1_done_pulse", 32'(done1), 32'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
